// File: rtl/pe_button_evt_pkg.sv
// Shared definitions for the button responder: register addresses,
// default button count, and the address decoder used by the read mux
// and the write-1-to-clear path.
package pe_button_evt_pkg;

  localparam int          BTN_NUM             = 5;
  localparam logic [11:0] PERI_ADDR_BTN_LEVEL = 12'h078;
  localparam logic [11:0] PERI_ADDR_BTN_EVENT = 12'h07C;
  // Release flags live in the upper byte lane of BTN_EVENT.
  localparam int          REL_EVT_LSB         = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_LEVEL,
    REG_EVENT
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [11:0] a);
    reg_sel_e sel;
    case (a)
      PERI_ADDR_BTN_LEVEL: sel = REG_LEVEL;
      PERI_ADDR_BTN_EVENT: sel = REG_EVENT;
      default:             sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pe_button_evt_btn_debounce.sv
// One button bit: two-flop synchroniser, 16-bit debounce counter and the
// stable (debounced) level. rise/fall are high during the cycle whose
// closing edge flips stable, so a flag register can capture the event on
// the same edge that the level changes.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic        sync1;
  logic        sync2;
  logic [15:0] cnt;
  logic        flip;

  // Bring the asynchronous pin into the clk domain.
  // NOTE: sequential state uses non-blocking (<=) so sync2 takes the old sync1, giving two real flop stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // The synchronised input has disagreed with stable for DEBOUNCE_CYCLES cycles.
  assign flip = (sync2 != stable) && (cnt == DEBOUNCE_CYCLES - 16'd1);
  assign rise = flip &  sync2;
  assign fall = flip & ~sync2;

  // Count consecutive disagreeing cycles; any return to stable restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (flip) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pe_button_evt.sv
// Memory-mapped button responder behind the Bridge.
//   0x078 BTN_LEVEL  debounced button levels (read-only)
//   0x07C BTN_EVENT  sticky press flags, write-1-to-clear
// Optional build macro BTN_RELEASE_EVT_EN adds sticky release flags in
// BTN_EVENT bits [NBTN+7:8]; without it those bits read 0 and no release
// logic exists. rdata is combinational from addr (single-cycle CPU).
module pe_button_evt
  import pe_button_evt_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          NBTN            = BTN_NUM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr,
  input  logic            wen,
  input  logic [31:0]     wdata,
  input  logic [NBTN-1:0] button,
  output logic [31:0]     rdata
);

  logic [NBTN-1:0] level;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] fall;
  logic [NBTN-1:0] evt_q;
  logic [NBTN-1:0] evt_clr;
  reg_sel_e        sel;
  logic            evt_wr;

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .button(button[gi]),
      .stable(level[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi])
    );
  end

  assign sel     = decode_addr(addr);
  assign evt_wr  = wen && (sel == REG_EVENT);
  assign evt_clr = evt_wr ? wdata[NBTN-1:0] : '0;

  // Press flags: clear requested bits, then OR in new presses so a set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_q <= '0;
    else     evt_q <= (evt_q & ~evt_clr) | rise;
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [NBTN-1:0] rel_q;
  logic [NBTN-1:0] rel_clr;

  assign rel_clr = evt_wr ? wdata[NBTN+REL_EVT_LSB-1:REL_EVT_LSB] : '0;

  // Release flags: same clear-then-set ordering as the press flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_q <= '0;
    else     rel_q <= (rel_q & ~rel_clr) | fall;
  end

  // Write-data bits outside the flag lanes have no register behind them.
  logic unused_bits;
  assign unused_bits = ^wdata;
`else
  // Without release flags the fall pulses and most write-data bits are unused.
  logic unused_bits;
  assign unused_bits = ^{wdata, fall};
`endif

  // Read mux: pure function of addr and register state, unmapped reads 0.
  always_comb begin
    // NOTE: rdata is given a default before the case so every path assigns it and no latch is inferred.
    rdata = '0;
    unique case (sel)
      REG_LEVEL: rdata[NBTN-1:0] = level;
      REG_EVENT: begin
        rdata[NBTN-1:0] = evt_q;
`ifdef BTN_RELEASE_EVT_EN
        rdata[NBTN+REL_EVT_LSB-1:REL_EVT_LSB] = rel_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_button_evt.sv
// Directed bench for pe_button_evt with DEBOUNCE_CYCLES=4.
// Inputs change just after the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
module tb_pe_button_evt;

  localparam logic [15:0] DB   = 16'd4;
  localparam int          NBTN = 5;
  localparam int          LAT  = 6;   // DEBOUNCE_CYCLES + 2 edges
`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     addr;
  logic            wen;
  logic [31:0]     wdata;
  logic [NBTN-1:0] button;
  logic [31:0]     rdata;

  int checks   = 0;
  int failures = 0;

  pe_button_evt #(
    .DEBOUNCE_CYCLES(DB),
    .NBTN           (NBTN)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wen   (wen),
    .wdata (wdata),
    .button(button),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
    wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; addr = '0; wen = 1'b0; wdata = '0; button = '0;
    tick(2);
    rst = 1'b0;
    tick();
    rd(12'h078, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_level got=%h exp=%h", d, 32'h0); end
    rd(12'h07C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_event got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d;
    logic [31:0] exp;
    button = 5'b00100;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      exp = (k >= LAT) ? 32'h4 : 32'h0;
      rd(12'h078, d); checks++;
      if (d !== exp) begin failures++; $display("FAIL press_level k=%0d got=%h exp=%h", k, d, exp); end
      if (k == LAT) begin
        rd(12'h07C, d); checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL press_event got=%h exp=%h", d, 32'h4); end
      end
    end
    // Release: level drops, no new press flag.
    button = '0;
    tick(LAT);
    rd(12'h078, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL release_level got=%h exp=%h", d, 32'h0); end
    exp = REL_EN ? 32'h404 : 32'h4;
    rd(12'h07C, d); checks++;
    if (d !== exp) begin failures++; $display("FAIL release_no_press got=%h exp=%h", d, exp); end
    wr(12'h07C, 32'hFFFF_FFFF);
    rd(12'h07C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL clear_all got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    logic        pattern [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8 + LAT; k++) begin
      button[0] = (k < 8) ? pattern[k] : 1'b0;
      tick();
      rd(12'h078, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL bounce_level k=%0d got=%h exp=%h", k, d, 32'h0); end
    end
    rd(12'h07C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL bounce_event got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    logic [31:0] exp;
    button = 5'b00101;
    tick(LAT);
    rd(12'h07C, d); checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL w1c_setup got=%h exp=%h", d, 32'h5); end
    wr(12'h07C, 32'h1);
    rd(12'h07C, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL w1c_partial got=%h exp=%h", d, 32'h4); end
    wr(12'h078, 32'h1F);
    rd(12'h078, d); checks++;
    if (d !== 32'h5) begin failures++; $display("FAIL level_write_ignored got=%h exp=%h", d, 32'h5); end
    rd(12'h07C, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL level_write_evt got=%h exp=%h", d, 32'h4); end
    wr(12'h070, 32'hFFFF_FFFF);
    rd(12'h07C, d); checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL unmapped_write got=%h exp=%h", d, 32'h4); end
    button = '0;
    tick(LAT);
    exp = REL_EN ? 32'h504 : 32'h4;
    rd(12'h07C, d); checks++;
    if (d !== exp) begin failures++; $display("FAIL w1c_after_release got=%h exp=%h", d, exp); end
    wr(12'h07C, 32'hFFFF_FFFF);
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    button = 5'b00010;
    tick(LAT - 1);
    rd(12'h078, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL setwin_pre_level got=%h exp=%h", d, 32'h0); end
    // Clear lands on the same edge that stable[1] rises.
    wr(12'h07C, 32'h2);
    rd(12'h07C, d); checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL set_wins got=%h exp=%h", d, 32'h2); end
    wr(12'h07C, 32'h2);
    rd(12'h07C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL later_clear got=%h exp=%h", d, 32'h0); end
    button = '0;
    tick(LAT);
    wr(12'h07C, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] exp;
    button = 5'b01000;
    tick(3);
    #2 rst = 1'b1;
    rd(12'h078, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_async_level got=%h exp=%h", d, 32'h0); end
    rd(12'h07C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_async_event got=%h exp=%h", d, 32'h0); end
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      exp = (k >= LAT) ? 32'h8 : 32'h0;
      rd(12'h07C, d); checks++;
      if (d !== exp) begin failures++; $display("FAIL rst_held_event k=%0d got=%h exp=%h", k, d, exp); end
    end
    rd(12'h070, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
    button = '0;
    tick(LAT);
    wr(12'h07C, 32'hFFFF_FFFF);
  endtask

`ifdef BTN_RELEASE_EVT_EN
  task automatic test_release_evt();
    logic [31:0] d;
    button = 5'b10000;
    tick(LAT);
    button = '0;
    tick(LAT);
    rd(12'h07C, d); checks++;
    if (d !== 32'h1010) begin failures++; $display("FAIL release_evt got=%h exp=%h", d, 32'h1010); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c();
    test_set_wins();
    test_reset_mid();
`ifdef BTN_RELEASE_EVT_EN
    test_release_evt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
